// File: rtl/axi_decerr_slave_pkg.sv
// Shared AXI codes, field types and default channel structs for the decode-error slave.
package axi_decerr_slave_pkg;

   typedef logic [1:0] axi_resp_t;
   typedef logic [7:0] len_t;
   typedef logic [5:0] atop_t;

   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_EXOKAY = 2'b01;
   localparam axi_resp_t RESP_SLVERR = 2'b10;
   localparam axi_resp_t RESP_DECERR = 2'b11;

   // Atomic ops with this bit set also return read data.
   localparam int unsigned ATOP_R_RESP = 5;

   typedef struct packed {
      logic [0:0]  id;
      logic [31:0] addr;
      len_t        len;
      logic [2:0]  size;
      logic [1:0]  burst;
      atop_t       atop;
      logic        user;
   } axi_aw_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic        user;
   } axi_w_t;

   typedef struct packed {
      logic [0:0] id;
      axi_resp_t  resp;
      logic       user;
   } axi_b_t;

   typedef struct packed {
      logic [0:0]  id;
      logic [31:0] addr;
      len_t        len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        user;
   } axi_ar_t;

   typedef struct packed {
      logic [0:0]  id;
      logic [63:0] data;
      axi_resp_t   resp;
      logic        last;
      logic        user;
   } axi_r_t;

   typedef struct packed {
      axi_aw_t aw;
      logic    aw_valid;
      axi_w_t  w;
      logic    w_valid;
      logic    b_ready;
      axi_ar_t ar;
      logic    ar_valid;
      logic    r_ready;
   } axi_req_t;

   typedef struct packed {
      logic   aw_ready;
      logic   ar_ready;
      logic   w_ready;
      axi_b_t b;
      logic   b_valid;
      axi_r_t r;
      logic   r_valid;
   } axi_rsp_t;

endpackage

// File: rtl/axi_decerr_slave_fifo.sv
// Registered-output FIFO (no fall-through); push ignored when full, pop ignored when empty.
module axi_decerr_slave_fifo #(
   parameter int unsigned Depth = 1,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             testmode_i,
   output logic             full_o,
   output logic             empty_o,
   input  logic [Width-1:0] data_i,
   input  logic             push_i,
   output logic [Width-1:0] data_o,
   input  logic             pop_i
);

   localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW  = $clog2(Depth + 1);

   typedef logic [AddrW-1:0] ptr_t;
   typedef logic [CntW-1:0]  cnt_t;

   localparam ptr_t LastPtr = ptr_t'(Depth - 1);
   localparam cnt_t FullCnt = cnt_t'(Depth);

   logic [Depth-1:0][Width-1:0] mem_d, mem_q;
   ptr_t wptr_d, wptr_q, rptr_d, rptr_q;
   cnt_t cnt_d, cnt_q;
   logic push_ok, pop_ok;
   logic unused_test;

   assign unused_test = testmode_i;
   assign full_o      = (cnt_q == FullCnt);
   assign empty_o     = (cnt_q == '0);
   assign data_o      = mem_q[rptr_q];

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      cnt_d   = cnt_q;
      push_ok = push_i && !full_o;
      pop_ok  = pop_i && !empty_o;
      if (push_ok) begin
         mem_d[wptr_q] = data_i;
         wptr_d        = (wptr_q == LastPtr) ? '0 : wptr_q + ptr_t'(1);
      end
      if (pop_ok) begin
         rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + ptr_t'(1);
      end
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + cnt_t'(1);
      end else if (pop_ok && !push_ok) begin
         cnt_d = cnt_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/axi_decerr_slave.sv
// Terminal AXI4+ATOP slave: answers every write with one B and every read (or
// read-returning atomic) with len+1 R beats, all carrying a fixed error response.
module axi_decerr_slave
   import axi_decerr_slave_pkg::*;
#(
   parameter int unsigned AxiIdWidth = 1,
   parameter type         req_t      = axi_req_t,
   parameter type         resp_t     = axi_rsp_t,
   parameter axi_resp_t   Resp       = RESP_DECERR,
   parameter logic [63:0] RespData   = 64'hCA11AB1EBADCAB1E,
   parameter bit          ATOPs      = 1'b1,
   parameter int unsigned MaxTrans   = 1
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  test_i,
   input  req_t  slv_req_i,
   output resp_t slv_resp_o
);

   typedef logic [AxiIdWidth-1:0] id_t;
   typedef struct packed {
      id_t  id;
      len_t len;
   } ar_entry_t;

   logic      aw_full, aw_empty, aw_push, aw_pop;
   id_t       aw_head;
   logic      ar_full, ar_empty, ar_push, ar_pop;
   ar_entry_t ar_in, ar_head;
   logic      atop_r, atop_push;
   logic      aw_ready, ar_ready, w_ready, r_valid, r_last;
   logic      b_valid_d, b_valid_q;
   id_t       b_id_d, b_id_q;
   len_t      cnt_d, cnt_q;
   logic      unused_req;

   // Only ids, lens, atop and handshake bits matter; payloads are dropped.
   assign unused_req = ^slv_req_i;

   always_comb begin
      atop_r    = ATOPs && slv_req_i.aw.atop[ATOP_R_RESP];
      aw_ready  = !aw_full && (!atop_r || !ar_full);
      aw_push   = slv_req_i.aw_valid && aw_ready;
      atop_push = aw_push && atop_r;
      // A read-returning atomic claims the AR queue write port this cycle.
      ar_ready  = !ar_full && !atop_push;
      ar_push   = atop_push || (slv_req_i.ar_valid && ar_ready);
      if (atop_push) begin
         ar_in.id  = id_t'(slv_req_i.aw.id);
         ar_in.len = slv_req_i.aw.len;
      end else begin
         ar_in.id  = id_t'(slv_req_i.ar.id);
         ar_in.len = slv_req_i.ar.len;
      end

      w_ready   = !aw_empty && !b_valid_q;
      aw_pop    = w_ready && slv_req_i.w_valid && slv_req_i.w.last;
      b_valid_d = b_valid_q;
      b_id_d    = b_id_q;
      if (b_valid_q && slv_req_i.b_ready) b_valid_d = 1'b0;
      if (aw_pop) begin
         b_valid_d = 1'b1;
         b_id_d    = aw_head;
      end

      r_valid = !ar_empty;
      r_last  = (cnt_q == ar_head.len);
      cnt_d   = cnt_q;
      ar_pop  = 1'b0;
      if (r_valid && slv_req_i.r_ready) begin
         if (r_last) begin
            cnt_d  = '0;
            ar_pop = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = aw_ready;
      slv_resp_o.ar_ready = ar_ready;
      slv_resp_o.w_ready  = w_ready;
      slv_resp_o.b_valid  = b_valid_q;
      slv_resp_o.b.id     = b_id_q;
      slv_resp_o.b.resp   = b_valid_q ? Resp : '0;
      slv_resp_o.r_valid  = r_valid;
      slv_resp_o.r.id     = r_valid ? ar_head.id : '0;
      slv_resp_o.r.resp   = r_valid ? Resp : '0;
      slv_resp_o.r.last   = r_valid && r_last;
      // Fill pattern is truncated or zero-extended to the bus data width.
      for (int i = 0; i < $bits(slv_resp_o.r.data); i++) begin
         slv_resp_o.r.data[i] = (r_valid && (i < 64)) ? RespData[i % 64] : 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         b_valid_q <= 1'b0;
         b_id_q    <= '0;
         cnt_q     <= '0;
      end else begin
         b_valid_q <= b_valid_d;
         b_id_q    <= b_id_d;
         cnt_q     <= cnt_d;
      end
   end

   axi_decerr_slave_fifo #(
      .Depth (MaxTrans),
      .Width (AxiIdWidth)
   ) u_aw_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .testmode_i (test_i),
      .full_o     (aw_full),
      .empty_o    (aw_empty),
      .data_i     (id_t'(slv_req_i.aw.id)),
      .push_i     (aw_push),
      .data_o     (aw_head),
      .pop_i      (aw_pop)
   );

   axi_decerr_slave_fifo #(
      .Depth (MaxTrans),
      .Width ($bits(ar_entry_t))
   ) u_ar_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .testmode_i (test_i),
      .full_o     (ar_full),
      .empty_o    (ar_empty),
      .data_i     (ar_in),
      .push_i     (ar_push),
      .data_o     (ar_head),
      .pop_i      (ar_pop)
   );

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Directed bench for axi_decerr_slave: main instance (MaxTrans=4, ATOPs=1) and
// a second instance (MaxTrans=1, ATOPs=0).
module tb_axi_decerr_slave;
   import axi_decerr_slave_pkg::*;

   typedef struct packed {
      logic [3:0] id; logic [31:0] addr; len_t len; logic [2:0] size;
      logic [1:0] burst; atop_t atop; logic user;
   } tb_aw_t;
   typedef struct packed {
      logic [63:0] data; logic [7:0] strb; logic last; logic user;
   } tb_w_t;
   typedef struct packed {
      logic [3:0] id; logic [1:0] resp; logic user;
   } tb_b_t;
   typedef struct packed {
      logic [3:0] id; logic [31:0] addr; len_t len; logic [2:0] size;
      logic [1:0] burst; logic user;
   } tb_ar_t;
   typedef struct packed {
      logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; logic user;
   } tb_r_t;
   typedef struct packed {
      tb_aw_t aw; logic aw_valid; tb_w_t w; logic w_valid; logic b_ready;
      tb_ar_t ar; logic ar_valid; logic r_ready;
   } tb_req_t;
   typedef struct packed {
      logic aw_ready; logic ar_ready; logic w_ready; tb_b_t b; logic b_valid;
      tb_r_t r; logic r_valid;
   } tb_rsp_t;

   localparam logic [63:0] FILL = 64'hCA11AB1EBADCAB1E;

   logic    clk = 1'b0;
   logic    rst_n;
   tb_req_t req, req2;
   tb_rsp_t rsp, rsp2;
   int      n_cmp = 0;
   int      n_err = 0;

   always #5 clk = ~clk;

   axi_decerr_slave #(
      .AxiIdWidth (4), .req_t (tb_req_t), .resp_t (tb_rsp_t),
      .MaxTrans (4), .ATOPs (1'b1)
   ) u_dut (
      .clk_i (clk), .rst_ni (rst_n), .test_i (1'b0),
      .slv_req_i (req), .slv_resp_o (rsp)
   );

   axi_decerr_slave #(
      .AxiIdWidth (4), .req_t (tb_req_t), .resp_t (tb_rsp_t),
      .MaxTrans (1), .ATOPs (1'b0)
   ) u_dut2 (
      .clk_i (clk), .rst_ni (rst_n), .test_i (1'b0),
      .slv_req_i (req2), .slv_resp_o (rsp2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_id [5];
      logic       exp_last [5];
      int         k;

      req = '0; req2 = '0; rst_n = 1'b0;
      #12;
      chk("rst_b_valid", rsp.b_valid, 0);
      chk("rst_r_valid", rsp.r_valid, 0);
      chk("rst_w_ready", rsp.w_ready, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      #1;
      chk("rst_aw_ready", rsp.aw_ready, 1);
      chk("rst_ar_ready", rsp.ar_ready, 1);
      chk("rst_b_id", rsp.b.id, 0);
      chk("rst_r_data", rsp.r.data, 0);

      // single write, W offered before AW
      req.w_valid = 1; req.w.last = 1; req.w.data = 64'h1234; req.w.strb = 8'hff;
      #1 chk("w_ready_before_aw", rsp.w_ready, 0);
      req.aw_valid = 1; req.aw.id = 4'd3; req.aw.len = 0;
      #1 chk("wr_aw_ready", rsp.aw_ready, 1);
      tick;
      req.aw_valid = 0;
      #1 chk("wr_w_ready", rsp.w_ready, 1);
      chk("wr_b_not_yet", rsp.b_valid, 0);
      tick;
      req.w_valid = 0;
      #1 chk("wr_b_valid", rsp.b_valid, 1);
      chk("wr_b_id", rsp.b.id, 3);
      chk("wr_b_resp", rsp.b.resp, 2'b11);
      tick;
      chk("wr_b_hold", rsp.b_valid, 1);
      chk("wr_b_hold_id", rsp.b.id, 3);
      req.b_ready = 1;
      tick;
      req.b_ready = 0;
      #1 chk("wr_b_clear", rsp.b_valid, 0);

      // burst read len=3
      req.ar_valid = 1; req.ar.id = 4'd5; req.ar.len = 8'd3; req.r_ready = 1;
      #1 chk("rd_ar_ready", rsp.ar_ready, 1);
      chk("rd_r_not_yet", rsp.r_valid, 0);
      tick;
      req.ar_valid = 0;
      for (int b = 0; b < 4; b++) begin
         #1;
         chk($sformatf("rd_valid_%0d", b), rsp.r_valid, 1);
         chk($sformatf("rd_id_%0d", b), rsp.r.id, 5);
         chk($sformatf("rd_data_%0d", b), rsp.r.data, FILL);
         chk($sformatf("rd_resp_%0d", b), rsp.r.resp, 2'b11);
         chk($sformatf("rd_last_%0d", b), rsp.r.last, (b == 3) ? 1 : 0);
         tick;
      end
      #1 chk("rd_done", rsp.r_valid, 0);

      // AW back-pressure at four outstanding
      req.r_ready = 0;
      for (int i = 0; i < 4; i++) begin
         req.aw_valid = 1; req.aw.id = 4'(i);
         #1 chk($sformatf("bp_aw_ready_%0d", i), rsp.aw_ready, 1);
         tick;
      end
      req.aw.id = 4'd4;
      #1 chk("bp_aw_full", rsp.aw_ready, 0);
      tick;
      chk("bp_aw_full_hold", rsp.aw_ready, 0);
      req.w_valid = 1; req.w.last = 1;
      #1 chk("bp_w_ready", rsp.w_ready, 1);
      chk("bp_aw_full_on_pop", rsp.aw_ready, 0);
      tick;
      req.w_valid = 0;
      #1 chk("bp_aw_free", rsp.aw_ready, 1);
      chk("bp_b_valid", rsp.b_valid, 1);
      chk("bp_b_id0", rsp.b.id, 0);
      tick;
      req.aw_valid = 0;
      req.b_ready = 1; req.w_valid = 1;
      for (int j = 1; j <= 4; j++) begin
         tick;
         tick;
         chk($sformatf("ord_b_valid_%0d", j), rsp.b_valid, 1);
         chk($sformatf("ord_b_id_%0d", j), rsp.b.id, 4'(j));
      end
      req.w_valid = 0;
      tick;
      req.b_ready = 0;
      #1 chk("bp_b_drained", rsp.b_valid, 0);
      chk("bp_w_idle", rsp.w_ready, 0);

      // AR back-pressure and ordering under random r_ready
      exp_id   = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4};
      exp_last = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         req.ar_valid = 1; req.ar.id = 4'(i + 1); req.ar.len = (i == 0) ? 8'd1 : 8'd0;
         #1 chk($sformatf("bp_ar_ready_%0d", i), rsp.ar_ready, 1);
         tick;
      end
      req.ar.id = 4'd5; req.ar.len = 0;
      #1 chk("bp_ar_full", rsp.ar_ready, 0);
      tick;
      req.ar_valid = 0;
      k = 0;
      for (int c = 0; c < 200 && k < 5; c++) begin
         req.r_ready = 1'($urandom_range(0, 1));
         #1;
         if (rsp.r_valid && req.r_ready) begin
            chk($sformatf("ord_r_id_%0d", k), rsp.r.id, exp_id[k]);
            chk($sformatf("ord_r_last_%0d", k), rsp.r.last, exp_last[k]);
            k++;
         end
         tick;
      end
      chk("ord_r_beats", 64'(k), 5);
      req.r_ready = 0;
      #1 chk("ord_r_drained", rsp.r_valid, 0);

      // read-returning atomic, racing a plain AR
      req.aw_valid = 1; req.aw.id = 4'd9; req.aw.len = 8'd1; req.aw.atop = 6'b100000;
      req.ar_valid = 1; req.ar.id = 4'd6; req.ar.len = 0;
      #1 chk("atop_aw_ready", rsp.aw_ready, 1);
      chk("atop_ar_blocked", rsp.ar_ready, 0);
      tick;
      req.aw_valid = 0; req.aw.atop = 0;
      #1 chk("atop_ar_ready", rsp.ar_ready, 1);
      tick;
      req.ar_valid = 0;
      req.w_valid = 1; req.w.last = 1;
      tick;
      req.w_valid = 0;
      #1 chk("atop_b_valid", rsp.b_valid, 1);
      chk("atop_b_id", rsp.b.id, 9);
      req.b_ready = 1; req.r_ready = 1;
      exp_id[0] = 4'd9; exp_id[1] = 4'd9; exp_id[2] = 4'd6;
      exp_last[0] = 1'b0; exp_last[1] = 1'b1; exp_last[2] = 1'b1;
      for (int b = 0; b < 3; b++) begin
         #1;
         chk($sformatf("atop_r_valid_%0d", b), rsp.r_valid, 1);
         chk($sformatf("atop_r_id_%0d", b), rsp.r.id, exp_id[b]);
         chk($sformatf("atop_r_last_%0d", b), rsp.r.last, exp_last[b]);
         tick;
      end
      #1 chk("atop_r_done", rsp.r_valid, 0);
      chk("atop_b_done", rsp.b_valid, 0);
      req.b_ready = 0; req.r_ready = 0;

      // ATOPs disabled, single-entry queues
      req2.aw_valid = 1; req2.aw.id = 4'd9; req2.aw.len = 8'd1; req2.aw.atop = 6'b100000;
      #1 chk("na_aw_ready", rsp2.aw_ready, 1);
      tick;
      req2.aw_valid = 0;
      #1 chk("na_aw_full", rsp2.aw_ready, 0);
      chk("na_ar_ready", rsp2.ar_ready, 1);
      req2.w_valid = 1; req2.w.last = 1;
      tick;
      req2.w_valid = 0;
      #1 chk("na_b_valid", rsp2.b_valid, 1);
      chk("na_b_id", rsp2.b.id, 9);
      chk("na_no_r", rsp2.r_valid, 0);
      req2.b_ready = 1;
      tick;
      tick;
      chk("na_no_r_later", rsp2.r_valid, 0);
      chk("na_b_done", rsp2.b_valid, 0);
      req2.b_ready = 0;

      // asynchronous reset in the middle of a read burst
      req.ar_valid = 1; req.ar.id = 4'd2; req.ar.len = 8'd3; req.r_ready = 1;
      tick;
      req.ar_valid = 0;
      tick;
      tick;
      chk("rst_mid_pre", rsp.r_valid, 1);
      rst_n = 1'b0;
      #1 chk("rst_mid_r_valid", rsp.r_valid, 0);
      chk("rst_mid_r_id", rsp.r.id, 0);
      req.r_ready = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      req.ar_valid = 1; req.ar.id = 4'd7; req.ar.len = 0;
      #1;
      tick;
      req.ar_valid = 0; req.r_ready = 1;
      #1 chk("post_rst_valid", rsp.r_valid, 1);
      chk("post_rst_id", rsp.r.id, 7);
      chk("post_rst_last", rsp.r.last, 1);
      tick;
      chk("post_rst_one_beat", rsp.r_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_decerr_slave.md
Name: axi_decerr_slave

Overview:
- Terminal AXI4+ATOP slave that completes every transaction it receives with a fixed error response, without touching memory.
- One instance sits behind each crossbar slave-port demultiplexer, on the extra port index NoMstPorts.
- That port is selected whenever the address decoder flags a decode error.
- Keeps the protocol legal: correct IDs, beat counts and last flags.

Parameters:
- AxiIdWidth, 1: width of the AXI ID field in AW/AR/B/R.
- req_t, logic: AXI request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
- resp_t, logic: AXI response struct (aw_ready, ar_ready, w_ready, b, b_valid, r, r_valid).
- Resp, axi_pkg::RESP_DECERR (2'b11): value driven on b.resp and r.resp.
- RespData, 64'hCA11AB1EBADCAB1E: value driven on r.data, truncated or zero-extended to the data width.
- ATOPs, 1: 1 = honour aw.atop; 0 = treat aw.atop as zero.
- MaxTrans, 1: outstanding write and outstanding read transactions accepted, each counted separately; must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- test_i  in  1  DFT test-mode pass-through to storage elements; no functional effect.
- slv_req_i  in  req_t  AXI request from upstream demux.
- slv_resp_o  out  resp_t  AXI response to upstream demux.

Behaviour:
- Reset values:
  - All valids 0.
  - All FIFOs empty, beat counter 0.
  - aw_ready and ar_ready 1 from the first cycle after reset.
  - b and r payload fields 0.
- Write path:
  - AW FIFO (depth MaxTrans) stores aw.id.
  - aw_ready = AW FIFO not full. If ATOPs=1 and aw.atop[5]=1, aw_ready additionally requires AR FIFO not full.
  - Push on aw_valid & aw_ready.
  - w_ready = AW FIFO not empty & !b_valid. W data and strb are discarded.
  - On a W handshake with w.last=1: pop the AW FIFO; next cycle b_valid=1 with b.id = popped id, b.resp = Resp, b.user = 0.
  - B held stable until b_ready; b_valid clears on the handshake cycle edge.
  - W beats arriving before their AW are stalled (w_ready=0).
- Read path:
  - AR FIFO (depth MaxTrans) stores {id, len}.
  - ar_ready = AR FIFO not full; push on handshake.
  - r_valid = AR FIFO not empty. The FIFO is registered, so earliest r_valid is the cycle after the AR handshake.
  - r.id = head id, r.data = RespData, r.resp = Resp, r.user = 0.
  - r.last = (beat counter == head len).
  - Counter increments on each R handshake. On the last beat, the counter resets to 0 and the FIFO pops.
  - Exactly len+1 beats per AR.
- ATOPs (ATOPs=1): an AW with atop[5]=1 (ATOP_R_RESP) also pushes {aw.id, aw.len} into the AR FIFO in the same cycle. That produces a B and len+1 R beats.
- Simultaneous AR push and ATOP push in one cycle: the ATOP has priority; ar_ready=0 that cycle.
- Full FIFOs: ready low, no loss. Push and pop in the same cycle on a full FIFO are allowed only for the pop-then-push case: ready remains low when full.
- Reset mid-transaction: all state is dropped immediately and asynchronously; outputs return to reset values.
- Arbitrary valid/ready interleavings must preserve AXI ordering: B in AW order, R in AR order, no interleaving of R bursts.

Decomposition:
- axi_pkg (shared):
  - resp_t codes RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - ATOP_R_RESP bit index (5).
  - len_t (8 bit), atop_t.
- Sub-module: fifo_v3 (existing common-cells FIFO), instantiated twice for the AW-ID and AR-{id,len} queues, with fall-through disabled.

Test Plan:
- Single write: AW id=3 len=0 then W last -> B with id=3, resp=2'b11 one cycle after W handshake; w_ready=0 before AW.
- Burst read: AR id=5 len=3, r_ready=1 -> 4 R beats id=5, data=64'hCA11AB1EBADCAB1E, resp=2'b11, r.last only on beat 4.
- Back-pressure, MaxTrans=4: 5 AWs without W -> fifth AW stalls (aw_ready=0) until the first W last is consumed. 5 ARs with r_ready=0 -> ar_ready low after 4.
- Ordering: ARs id 1 (len 1) then id 2 (len 0) with random r_ready -> R ids 1,1,2; B ids follow AW order 7,8.
- ATOP: AW atop=6'b100000 id=9 len=1 with one W last beat -> B id=9 plus 2 R beats id=9, last on beat 2. With ATOPs=0 -> only B.
- Reset during an R burst mid-beat -> r_valid=0 immediately, counter 0. A new AR len=0 then returns exactly 1 beat.
